// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier slice:
//   - MULT_N_DEFAULT : default operand width N
//   - mult_state_e   : controller state encoding (3 bits)
//   - acc_width()    : accumulator width for a given N (2N+1)
//   - cnt_width()    : step counter width for a given N
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int unsigned MULT_N_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } mult_state_e;

  // Accumulator holds the running partial product (N+1 bits, carry included)
  // above the shrinking multiplier (N bits).
  function automatic int unsigned acc_width(input int unsigned n);
    return 2 * n + 1;
  endfunction

  // The counter only has to reach N-1, so $clog2(N) bits suffice.
  // A degenerate N of 1 still needs one bit to be a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiplier_control_if.sv
// -----------------------------------------------------------------------------
// multiplier_control_if
// Control handshake between a requester/accumulator datapath and the
// multiplier sequencer.
//   St   : start request (requester -> controller), level
//   M    : accumulator bit 0 (datapath -> controller)
//   Load : load operands strobe (controller -> datapath)
//   Sh   : shift-right strobe (controller -> datapath)
//   Ad   : add multiplicand strobe (controller -> datapath)
//   Busy : operation in progress (controller -> requester)
//   Done : product valid, held until St drops (controller -> requester)
// Modports: master = requester/datapath side, slave = controller side.
// -----------------------------------------------------------------------------
interface multiplier_control_if;

  logic St;
  logic M;
  logic Load;
  logic Sh;
  logic Ad;
  logic Busy;
  logic Done;

  modport master (
    output St,
    output M,
    input  Load,
    input  Sh,
    input  Ad,
    input  Busy,
    input  Done
  );

  modport slave (
    input  St,
    input  M,
    output Load,
    output Sh,
    output Ad,
    output Busy,
    output Done
  );

endinterface

// File: rtl/mult_acc.sv
// -----------------------------------------------------------------------------
// mult_acc
// Shift-and-add accumulator (2N+1 bits) driven by the controller strobes.
//   Clk          : clock, rising edge
//   Reset        : asynchronous active-high reset, clears the accumulator
//   Load         : acc <= {0, Multiplier}
//   Sh           : acc <= acc >> 1
//   Ad           : acc[2N:N] <= acc[2N-1:N] + Multiplicand
//   Multiplier   : N-bit multiplier operand
//   Multiplicand : N-bit multiplicand operand
//   Entradas     : accumulator contents; bit 0 feeds the controller's M,
//                  bits [2N-1:0] hold the product once Done is high
// -----------------------------------------------------------------------------
module mult_acc
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N_DEFAULT
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Load,
  input  logic           Sh,
  input  logic           Ad,
  input  logic [N-1:0]   Multiplier,
  input  logic [N-1:0]   Multiplicand,
  output logic [2*N:0]   Entradas
);

  localparam int unsigned AW = acc_width(N);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [N:0]    sum;

  // Bit 2N is always zero when an add happens (it is cleared by Load and
  // by every shift), so the add only needs the N bits below it plus carry.
  assign sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, Multiplicand};

  always_comb begin
    acc_d = acc_q;
    if (Load) begin
      acc_d = {{(N + 1){1'b0}}, Multiplier};
    end else if (Ad) begin
      acc_d = {sum, acc_q[N-1:0]};
    end else if (Sh) begin
      acc_d = {1'b0, acc_q[AW-1:1]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign Entradas = acc_q;

endmodule

// File: rtl/mult_step_counter.sv
// -----------------------------------------------------------------------------
// mult_step_counter
// Counts shift steps of one multiply operation.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset, clears the count
//   Clr   : synchronous clear (operation start)
//   Inc   : count one shift step
//   Last  : count == N-1, i.e. the step being issued now is the N-th shift
// -----------------------------------------------------------------------------
module mult_step_counter
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clr,
  input  logic Inc,
  output logic Last
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] TERM = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign Last = (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (Inc) begin
      // The terminal step returns the count to zero explicitly instead of
      // letting it roll over, so it never passes N-1.
      if (Last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multiplier_control.sv
// -----------------------------------------------------------------------------
// multiplier_control
// Sequencer for the shift-and-add multiplier. After a start request it
// issues one Load, then exactly N shifts with an add inserted before each
// shift whose multiplier LSB is 1. Done is held until St is dropped.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset; forces IDLE, outputs to 0
//   ctrl  : handshake interface (slave side): St, M in; Load, Sh, Ad,
//           Busy, Done out
// -----------------------------------------------------------------------------
module multiplier_control
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N_DEFAULT
) (
  input  logic               Clk,
  input  logic               Reset,
  multiplier_control_if.slave ctrl
);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] LOAD  = ST_LOAD;
  localparam logic [2:0] EVAL  = ST_EVAL;
  localparam logic [2:0] SHIFT = ST_SHIFT;
  localparam logic [2:0] DONE  = ST_DONE;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic load;
  logic sh;
  logic ad;
  logic busy;
  logic done;
  logic cnt_clr;
  logic cnt_inc;
  logic cnt_last;

  mult_step_counter #(
    .N(N)
  ) u_step_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (cnt_clr),
    .Inc   (cnt_inc),
    .Last  (cnt_last)
  );

  // Next state and strobe decode. Sh/Ad in EVAL depend on M (Mealy); M is
  // a registered accumulator bit, so there is no combinational loop.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sh      = 1'b0;
    ad      = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ctrl.St) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        cnt_clr = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        if (ctrl.M) begin
          // Add now, the matching shift follows in SHIFT.
          ad      = 1'b1;
          state_d = SHIFT;
        end else begin
          sh      = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        sh      = 1'b1;
        cnt_inc = 1'b1;
        state_d = cnt_last ? DONE : EVAL;
      end
      DONE: begin
        // No restart from here: St must fall before a new operation.
        if (!ctrl.St) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == LOAD) || (state_q == EVAL) || (state_q == SHIFT);
  assign done = (state_q == DONE);

  // Asynchronous reset puts the state in IDLE immediately, and every output
  // decodes to 0 from IDLE, so outputs drop without waiting for a clock.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl.Load = load;
  assign ctrl.Sh   = sh;
  assign ctrl.Ad   = ad;
  assign ctrl.Busy = busy;
  assign ctrl.Done = done;

endmodule

// File: tb/tb_multiplier_control.sv
// -----------------------------------------------------------------------------
// tb_multiplier_control
// Drives multiplier_control with mult_acc alongside it and checks strobe
// counts, strobe order, Done timing, handshake and products against a
// reference derived from the multiplier bits and plain multiplication.
// -----------------------------------------------------------------------------
module tb_multiplier_control;
  import mult_pkg::*;

  localparam int unsigned N = 32;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic [N-1:0]   mplier = '0;
  logic [N-1:0]   mcand = '0;
  logic [2*N:0]   acc_val;

  int checks = 0;
  int errors = 0;

  int   load_cnt = 0;
  int   sh_cnt = 0;
  int   ad_cnt = 0;
  int   busy_cnt = 0;
  logic prev_ad = 1'b0;
  int   trace_q[$];   // 1 = add, 2 = shift, in issue order
  int   op_num = 0;

  multiplier_control_if bus ();

  multiplier_control #(.N(N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .ctrl  (bus)
  );

  mult_acc #(.N(N)) u_acc (
    .Clk          (Clk),
    .Reset        (Reset),
    .Load         (bus.Load),
    .Sh           (bus.Sh),
    .Ad           (bus.Ad),
    .Multiplier   (mplier),
    .Multiplicand (mcand),
    .Entradas     (acc_val)
  );

  assign bus.M = acc_val[0];

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Reset) begin
      prev_ad = 1'b0;
    end else begin
      check("strobe_onehot", 64'(($countones({bus.Load, bus.Sh, bus.Ad}) <= 1)), 64'd1);
      if (prev_ad) check("ad_then_sh", 64'(bus.Sh), 64'd1);
      prev_ad = bus.Ad;
      if (bus.Load) load_cnt++;
      if (bus.Sh) begin
        sh_cnt++;
        trace_q.push_back(2);
      end
      if (bus.Ad) begin
        ad_cnt++;
        trace_q.push_back(1);
      end
      if (bus.Busy) busy_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    load_cnt = 0;
    sh_cnt   = 0;
    ad_cnt   = 0;
    busy_cnt = 0;
    trace_q.delete();
  endtask

  // mode 0: St pulsed; mode 1: St held through DONE; mode 2: St toggled
  // randomly while busy.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int mode);
    int p;
    int edges;
    int bad;
    int exp_q[$];
    logic [2*N-1:0] exp_p;
    p = $countones(a);
    exp_p = (2*N)'(a) * (2*N)'(b);
    for (int i = 0; i < int'(N); i++) begin
      if (a[i]) exp_q.push_back(1);
      exp_q.push_back(2);
    end

    @(negedge Clk);
    mplier = a;
    mcand  = b;
    clear_counts();
    bus.St = 1'b1;
    @(posedge Clk);   // edge k: St sampled
    #1;
    if (mode == 0) bus.St = 1'b0;
    if (mode == 2) bus.St = 1'($urandom_range(0, 1));
    edges = 0;
    while (edges < 200) begin
      @(posedge Clk);
      edges++;
      #1;
      if (bus.Done) break;
      if (mode == 2) bus.St = 1'($urandom_range(0, 1));
    end
    check("done_seen", 64'(bus.Done), 64'd1);
    check("done_edge", 64'(edges), 64'(1 + N + p));
    bus.St = (mode == 1);
    check("load_count", 64'(load_cnt), 64'd1);
    check("sh_count", 64'(sh_cnt), 64'(N));
    check("ad_count", 64'(ad_cnt), 64'(p));
    check("busy_len", 64'(busy_cnt), 64'(1 + N + p));
    check("product", 64'(acc_val[2*N-1:0]), 64'(exp_p));
    check("trace_len", 64'(trace_q.size()), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= trace_q.size() || trace_q[i] != exp_q[i]) bad++;
    end
    check("trace_order", 64'(bad), 64'd0);

    if (mode == 1) begin
      repeat (4) begin
        @(posedge Clk);
        #1;
        check("done_hold", 64'(bus.Done), 64'd1);
        check("no_restart", 64'(bus.Busy), 64'd0);
      end
      bus.St = 1'b0;
    end
    @(posedge Clk);
    #1;
    check("done_fall", 64'(bus.Done), 64'd0);
    check("idle_busy", 64'(bus.Busy), 64'd0);
    check("single_load", 64'(load_cnt), 64'd1);
    op_num++;
    $display("op %0d mode=%0d mplier=%08h mcand=%08h done_edge=%0d sh=%0d ad=%0d product=%016h",
             op_num, mode, a, b, edges, sh_cnt, ad_cnt, acc_val[2*N-1:0]);
  endtask

  initial begin
    bus.St = 1'b0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs", 64'({bus.Load, bus.Sh, bus.Ad, bus.Busy, bus.Done}), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("post_reset_idle", 64'({bus.Busy, bus.Done, bus.Load}), 64'd0);

    // Directed operations
    run_op(32'h0000_0005, 32'd3, 0);
    run_op(32'h0000_0000, N'($urandom), 0);
    run_op(32'hFFFF_FFFF, N'($urandom), 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(N'($urandom), N'($urandom), 1);
    run_op(N'($urandom), N'($urandom), 2);

    // Asynchronous reset after the 10th shift
    @(negedge Clk);
    mplier = N'($urandom);
    mcand  = N'($urandom);
    clear_counts();
    bus.St = 1'b1;
    @(posedge Clk);
    #1;
    bus.St = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      #1;
      if (sh_cnt >= 10) break;
    end
    check("sh_before_reset", 64'(sh_cnt), 64'd10);
    Reset = 1'b1;
    #1;
    check("reset_async_outputs", 64'({bus.Load, bus.Sh, bus.Ad, bus.Busy, bus.Done}), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("reset_release_idle", 64'({bus.Busy, bus.Done, bus.Load}), 64'd0);
    $display("op reset: asserted after %0d shifts", sh_cnt);
    run_op(N'($urandom), N'($urandom), 0);

    // Random scoreboard
    for (int i = 0; i < 200; i++) begin
      run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
